pipelined_carry_skip_adder: RTL

Parametrised, pipelined carry-skip adder/subtractor with a valid/ready stream interface. It is the successor to the fixed 32-bit combinational carry-skip adder and serves as the datapath adder in clocked arithmetic units. Skip blocks are grouped into pipeline stages. The result is skewed forward and realigned, giving 1 result/cycle throughput with full backpressure.

---
 rtl/pipelined_carry_skip_adder_if.sv | 40 ++++
 rtl/pipelined_carry_skip_adder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pipelined_carry_skip_adder_if.sv
// Stream bundle for the pipelined carry-skip adder: operand request side plus result side.
// Optional ovf result bit exists only when CSKIP_OVF_EN is defined.
interface pipelined_carry_skip_adder_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [TAG_W-1:0] out_tag;
`ifdef CSKIP_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, in_tag, out_ready,
        input  in_ready, out_valid, sum, cout, out_tag, ovf
    );
    modport slave (
        input  in_valid, a, b, cin, sub, in_tag, out_ready,
        output in_ready, out_valid, sum, cout, out_tag, ovf
    );
`else
    modport master (
        output in_valid, a, b, cin, sub, in_tag, out_ready,
        input  in_ready, out_valid, sum, cout, out_tag
    );
    modport slave (
        input  in_valid, a, b, cin, sub, in_tag, out_ready,
        output in_ready, out_valid, sum, cout, out_tag
    );
`endif
endinterface

// File: rtl/pipelined_carry_skip_adder.sv
// Pipelined carry-skip adder/subtractor; BLOCKS_PER_STAGE skip blocks per stage, skewed operands.
// Define CSKIP_OVF_EN to add the signed-overflow output bus.ovf.
module pipelined_carry_skip_adder #(
    parameter int WIDTH            = 32,
    parameter int BLOCK            = 4,
    parameter int BLOCKS_PER_STAGE = 2,
    parameter int TAG_W            = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    pipelined_carry_skip_adder_if.slave bus
);
    localparam int SW     = BLOCK * BLOCKS_PER_STAGE;
    localparam int NSTAGE = WIDTH / SW;

    // Offset of stage k's leftover b bits inside the flat b_q store.
    function automatic int b_off(input int k);
        return k * WIDTH - (SW * k * (k + 1)) / 2;
    endfunction

    localparam int BT  = b_off(NSTAGE - 1);
    localparam int BTD = (BT > 0) ? BT : 1;

    if ((WIDTH % SW) != 0 || BLOCK < 2 || WIDTH < SW) begin : g_param_check
        $error("pipelined_carry_skip_adder: WIDTH must be a multiple of BLOCK*BLOCKS_PER_STAGE and BLOCK >= 2");
    end

    // One pipeline segment: BLOCKS_PER_STAGE ripple blocks, each bypassed on group propagate.
    function automatic logic [SW:0] skip_seg(input logic [SW-1:0] x,
                                             input logic [SW-1:0] y,
                                             input logic          ci);
        logic [SW-1:0] s;
        logic          c_blk;
        logic          c_rip;
        logic          p_all;
        s     = '0;
        c_blk = ci;
        for (int j = 0; j < BLOCKS_PER_STAGE; j++) begin
            c_rip = c_blk;
            p_all = 1'b1;
            for (int i = 0; i < BLOCK; i++) begin
                s[j*BLOCK+i] = x[j*BLOCK+i] ^ y[j*BLOCK+i] ^ c_rip;
                c_rip        = (x[j*BLOCK+i] & y[j*BLOCK+i]) |
                               (c_rip & (x[j*BLOCK+i] ^ y[j*BLOCK+i]));
                p_all        = p_all & (x[j*BLOCK+i] ^ y[j*BLOCK+i]);
            end
            c_blk = p_all ? c_blk : c_rip;
        end
        return {c_blk, s};
    endfunction

    logic [NSTAGE-1:0]             vld_pipe;
    logic [NSTAGE-1:0]             vld_nx;
    logic [NSTAGE-1:0]             ld;
    logic [NSTAGE-1:0]             adv;
    logic [NSTAGE-1:0]             vin;
    logic [NSTAGE-1:0]             cy_q;
    logic [NSTAGE-1:0]             cy_nx;
    logic [NSTAGE-1:0][WIDTH-1:0]  x_q;
    logic [NSTAGE-1:0][WIDTH-1:0]  x_nx;
    logic [NSTAGE-1:0][TAG_W-1:0]  tag_q;
    logic [NSTAGE-1:0][TAG_W-1:0]  tag_nx;
    logic [BTD-1:0]                b_q;
    logic [BTD-1:0]                b_nx;
    logic [WIDTH-1:0]              b_eff;
    logic                          chain;
`ifdef CSKIP_OVF_EN
    logic                          ovf_q;
    logic                          ovf_nx;
`endif

    assign b_eff = bus.b ^ {WIDTH{bus.sub}};

    // Ready chain from the output back to stage 0; empty stages always accept.
    always_comb begin
        ld    = '0;
        adv   = '0;
        chain = bus.out_ready;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            adv[k] = vld_pipe[k] & chain;
            ld[k]  = ~vld_pipe[k] | adv[k];
            chain  = ld[k];
        end
    end

    // x_q[k] holds {unprocessed a bits, finished sum bits}; b_q holds unprocessed b bits.
    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        localparam int LO  = k * SW;
        localparam int REM = WIDTH - (k + 1) * SW;

        logic [WIDTH-1:0] x_cur;
        logic [WIDTH-1:0] x_upd;
        logic [SW-1:0]    b_cur;
        logic             c_cur;
        logic [TAG_W-1:0] t_cur;
        logic [SW:0]      res;
        logic             load;

        if (k == 0) begin : g_first
            assign x_cur  = bus.a;
            assign b_cur  = b_eff[SW-1:0];
            assign c_cur  = bus.sub | bus.cin;
            assign t_cur  = bus.in_tag;
            assign vin[0] = bus.in_valid;
            if (REM > 0) begin : g_rem
                assign b_nx[b_off(0) +: REM] = load ? b_eff[WIDTH-1:SW] : b_q[b_off(0) +: REM];
            end
        end else begin : g_next
            assign x_cur  = x_q[k-1];
            assign b_cur  = b_q[b_off(k-1) +: SW];
            assign c_cur  = cy_q[k-1];
            assign t_cur  = tag_q[k-1];
            assign vin[k] = vld_pipe[k-1];
            if (REM > 0) begin : g_rem
                assign b_nx[b_off(k) +: REM] = load ? b_q[b_off(k-1) + SW +: REM]
                                                    : b_q[b_off(k) +: REM];
            end
        end

        assign res  = skip_seg(x_cur[LO +: SW], b_cur, c_cur);
        assign load = ld[k] & vin[k];

        always_comb begin
            x_upd            = x_cur;
            x_upd[LO +: SW]  = res[SW-1:0];
        end

        assign vld_nx[k] = ld[k] ? vin[k] : vld_pipe[k];
        assign x_nx[k]   = load ? x_upd : x_q[k];
        assign cy_nx[k]  = load ? res[SW] : cy_q[k];
        assign tag_nx[k] = load ? t_cur : tag_q[k];

`ifdef CSKIP_OVF_EN
        // The last segment still sees the raw operand MSBs, so overflow is resolved here.
        if (k == NSTAGE - 1) begin : g_ovf
            assign ovf_nx = load ? ((x_cur[WIDTH-1] == b_cur[SW-1]) & (res[SW-1] != x_cur[WIDTH-1]))
                                 : ovf_q;
        end
`endif
    end

    if (BT == 0) begin : g_no_skew
        assign b_nx = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            cy_q     <= '0;
            x_q      <= '0;
            tag_q    <= '0;
            b_q      <= '0;
`ifdef CSKIP_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            vld_pipe <= vld_nx;
            cy_q     <= cy_nx;
            x_q      <= x_nx;
            tag_q    <= tag_nx;
            b_q      <= b_nx;
`ifdef CSKIP_OVF_EN
            ovf_q    <= ovf_nx;
`endif
        end
    end

    assign bus.in_ready  = ld[0];
    assign bus.out_valid = vld_pipe[NSTAGE-1];
    assign bus.sum       = x_q[NSTAGE-1];
    assign bus.cout      = cy_q[NSTAGE-1];
    assign bus.out_tag   = tag_q[NSTAGE-1];
`ifdef CSKIP_OVF_EN
    assign bus.ovf       = ovf_q;
`endif
endmodule
